// File: rtl/kamus_pkg.sv
// Shared types and default geometry for the kamus L1 instruction cache.
package kamus_pkg;

   localparam int L1I_NUM_LINES  = 64;
   localparam int L1I_LINE_WORDS = 4;
   localparam int L1I_ADDR_W     = 32;

   localparam int L1I_OFF_W      = $clog2(L1I_LINE_WORDS);
   localparam int L1I_IDX_W      = $clog2(L1I_NUM_LINES);
   localparam int L1I_LINE_LSB   = L1I_OFF_W + 2;
   localparam int L1I_TAG_W      = L1I_ADDR_W - L1I_IDX_W - L1I_LINE_LSB;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      REFILL_REQ,
      REFILL_DATA,
      RESP
   } l1i_state_e;

endpackage

// File: rtl/kamus_l1i_array.sv
// Tag, valid and data storage for the L1I; reads are combinational.
module kamus_l1i_array #(
   parameter int NUM_LINES  = 64,
   parameter int LINE_WORDS = 4,
   parameter int IDX_W      = 6,
   parameter int OFF_W      = 2,
   parameter int TAG_W      = 22
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic [OFF_W-1:0] rd_off,
   output logic [TAG_W-1:0] rd_tag,
   output logic             rd_valid,
   output logic [31:0]      rd_data,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [OFF_W-1:0] wr_off,
   input  logic [31:0]      wr_data,
   input  logic             tag_we,
   input  logic [TAG_W-1:0] tag_wdata
);

   logic [31:0]          data_mem [NUM_LINES*LINE_WORDS];
   logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
   logic [NUM_LINES-1:0] valid_q;

   // refill word writes and tag install (contents need no reset, valid gates them)
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_mem[{wr_idx, wr_off}] <= wr_data;
      end
      if (tag_we) begin
         tag_mem[wr_idx] <= tag_wdata;
      end
   end

   // valid bits: global clear wins over installing a line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (clear) begin
         valid_q <= '0;
      end else if (tag_we) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   assign rd_tag   = tag_mem[rd_idx];
   assign rd_valid = valid_q[rd_idx];
   assign rd_data  = data_mem[{rd_idx, rd_off}];

endmodule

// File: rtl/kamus_l1i_cache.sv
// Direct-mapped, read-only L1 instruction cache between IF and the instruction bus.
//
//   state       | meaning
//   IDLE        | no request in flight, grant any new fetch
//   LOOKUP      | compare tag of req_addr_q; hit responds, miss starts refill
//   REFILL_REQ  | line request held on the bus until mem_gnt_i
//   REFILL_DATA | collecting LINE_WORDS beats into the line
//   RESP        | answer the missed fetch from the freshly filled line
module kamus_l1i_cache
   import kamus_pkg::*;
#(
   parameter int NUM_LINES  = L1I_NUM_LINES,
   parameter int LINE_WORDS = L1I_LINE_WORDS
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   input  logic [31:0] instr_addr_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_data_o,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   output logic [31:0] mem_addr_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        miss_o
);

   localparam int OFF_W    = $clog2(LINE_WORDS);
   localparam int IDX_W    = $clog2(NUM_LINES);
   localparam int LINE_LSB = OFF_W + 2;
   localparam int TAG_W    = 32 - IDX_W - LINE_LSB;

   l1i_state_e       state_q, state_d;
   logic [31:0]      req_addr_q;
   logic [OFF_W-1:0] cnt_q;
   logic             kill_q;
   logic [31:0]      hold_q;

   logic [OFF_W-1:0] req_off;
   logic [IDX_W-1:0] req_idx;
   logic [TAG_W-1:0] req_tag;
   logic [TAG_W-1:0] rd_tag;
   logic             rd_valid;
   logic [31:0]      rd_data;
   logic             hit;
   logic             last_beat;
   logic             in_refill;

   logic             gnt;
   logic             valid;
   logic             miss;
   logic             mem_req;
   logic [31:0]      mem_addr;
   logic             arr_we;
   logic             tag_we;

   // byte-offset bits of the fetch address carry no information for word fetches
   logic             unused_addr_bits;
   assign unused_addr_bits = ^instr_addr_i[1:0];

   assign req_off   = req_addr_q[LINE_LSB-1:2];
   assign req_idx   = req_addr_q[LINE_LSB+IDX_W-1:LINE_LSB];
   assign req_tag   = req_addr_q[31:LINE_LSB+IDX_W];
   assign hit       = rd_valid && (rd_tag == req_tag);
   assign last_beat = mem_rvalid_i && (cnt_q == OFF_W'(LINE_WORDS-1));
   assign in_refill = (state_q == REFILL_REQ) || (state_q == REFILL_DATA);

   kamus_l1i_array #(
      .NUM_LINES  (NUM_LINES),
      .LINE_WORDS (LINE_WORDS),
      .IDX_W      (IDX_W),
      .OFF_W      (OFF_W),
      .TAG_W      (TAG_W)
   ) u_array (
      .clk       (clk_i),
      .rst       (rst_i),
      .clear     (flush_i),
      .rd_idx    (req_idx),
      .rd_off    (req_off),
      .rd_tag    (rd_tag),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .wr_en     (arr_we),
      .wr_idx    (req_idx),
      .wr_off    (cnt_q),
      .wr_data   (mem_rdata_i),
      .tag_we    (tag_we),
      .tag_wdata (req_tag)
   );

   // next-state and output decode
   always_comb begin
      state_d  = state_q;
      gnt      = 1'b0;
      valid    = 1'b0;
      miss     = 1'b0;
      mem_req  = 1'b0;
      mem_addr = '0;
      arr_we   = 1'b0;
      tag_we   = 1'b0;
      case (state_q)
         IDLE: begin
            gnt = instr_req_i && !flush_i;
            if (gnt) state_d = LOOKUP;
         end
         LOOKUP: begin
            if (flush_i) begin
               state_d = IDLE;
            end else if (hit) begin
               valid   = 1'b1;
               gnt     = instr_req_i;
               state_d = gnt ? LOOKUP : IDLE;
            end else begin
               miss    = 1'b1;
               state_d = REFILL_REQ;
            end
         end
         REFILL_REQ: begin
            // the bus handshake cannot be withdrawn, so a flush here only marks kill_q
            mem_req  = 1'b1;
            mem_addr = {req_addr_q[31:LINE_LSB], {LINE_LSB{1'b0}}};
            if (mem_gnt_i) state_d = REFILL_DATA;
         end
         REFILL_DATA: begin
            arr_we = mem_rvalid_i;
            if (last_beat) begin
               if (kill_q || flush_i) begin
                  state_d = IDLE;
               end else begin
                  tag_we  = 1'b1;
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            if (flush_i) begin
               state_d = IDLE;
            end else begin
               valid   = 1'b1;
               gnt     = instr_req_i;
               state_d = gnt ? LOOKUP : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (rst_i) gnt = 1'b0;
   end

   // state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // request address, beat counter, kill flag and held output word
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_addr_q <= '0;
         cnt_q      <= '0;
         kill_q     <= 1'b0;
         hold_q     <= '0;
      end else begin
         if (gnt) req_addr_q <= instr_addr_i;
         if (state_q == REFILL_REQ) begin
            cnt_q <= '0;
         end else if ((state_q == REFILL_DATA) && mem_rvalid_i) begin
            cnt_q <= cnt_q + OFF_W'(1);
         end
         if (flush_i && in_refill) begin
            kill_q <= 1'b1;
         end else if ((state_q == REFILL_DATA) && last_beat) begin
            kill_q <= 1'b0;
         end
         if (valid) hold_q <= rd_data;
      end
   end

   assign instr_gnt_o   = gnt;
   assign instr_valid_o = valid;
   assign instr_data_o  = valid ? rd_data : hold_q;
   assign miss_o        = miss;
   assign mem_req_o     = mem_req;
   assign mem_addr_o    = mem_addr;

endmodule

// File: tb/tb_kamus_l1i_cache.sv
// Directed scoreboard bench for kamus_l1i_cache.
module tb_kamus_l1i_cache;
   import kamus_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic        instr_req_i = 1'b0;
   logic        instr_gnt_o;
   logic [31:0] instr_addr_i = '0;
   logic        instr_valid_o;
   logic [31:0] instr_data_o;
   logic        mem_req_o;
   logic        mem_gnt_i = 1'b0;
   logic [31:0] mem_addr_o;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        miss_o;

   int checks = 0;
   int errors = 0;
   int miss_seen = 0;
   int mem_req_seen = 0;
   int waits;
   int req_before;
   logic [31:0] exp_q [$];

   kamus_l1i_cache dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .flush_i       (flush_i),
      .instr_req_i   (instr_req_i),
      .instr_gnt_o   (instr_gnt_o),
      .instr_addr_i  (instr_addr_i),
      .instr_valid_o (instr_valid_o),
      .instr_data_o  (instr_data_o),
      .mem_req_o     (mem_req_o),
      .mem_gnt_i     (mem_gnt_i),
      .mem_addr_o    (mem_addr_o),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i),
      .miss_o        (miss_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor: every presented response is matched against the oldest expectation
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (miss_o) miss_seen++;
         if (mem_req_o) mem_req_seen++;
         if (instr_valid_o) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_valid", instr_data_o, 32'hDEAD_DEAD);
            end else begin
               check_eq("resp_data", instr_data_o, exp_q.pop_front());
            end
         end
      end
   end

   // fetch: starts and ends one time unit after a rising edge
   task automatic fetch(input logic [31:0] addr, input logic [31:0] exp, input bit push,
                        output int w);
      instr_req_i  = 1'b1;
      instr_addr_i = addr;
      w = 0;
      @(negedge clk_i);
      while (!instr_gnt_o && w < 100) begin
         w++;
         @(negedge clk_i);
      end
      if (!instr_gnt_o) check_eq("gnt_timeout", {31'd0, instr_gnt_o}, 32'd1);
      if (push) exp_q.push_back(exp);
      @(posedge clk_i); #1;
      instr_req_i = 1'b0;
   endtask

   // memory side: grant after gdly cycles, then deliver nbeats words base+i
   task automatic serve(input logic [31:0] exp_addr, input int gdly, input logic [31:0] base,
                        input int nbeats, input bit gaps, input int flush_beat, input bit resp);
      int n = 0;
      @(negedge clk_i);
      while (!mem_req_o && n < 50) begin
         n++;
         @(negedge clk_i);
      end
      check_eq("mem_req", {31'd0, mem_req_o}, 32'd1);
      check_eq("mem_addr", mem_addr_o, exp_addr);
      repeat (gdly) @(negedge clk_i);
      if (gdly > 0) check_eq("mem_addr_held", mem_addr_o, exp_addr);
      mem_gnt_i = 1'b1;
      @(posedge clk_i); #1;
      mem_gnt_i = 1'b0;
      for (int b = 0; b < nbeats; b++) begin
         if (gaps && b > 0) begin
            @(posedge clk_i); #1;
         end
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = base + 32'(b);
         flush_i      = (b + 1 == flush_beat);
         @(posedge clk_i); #1;
         mem_rvalid_i = 1'b0;
         flush_i      = 1'b0;
      end
      if (nbeats == L1I_LINE_WORDS) begin
         @(negedge clk_i);
         check_eq("resp_timing", {31'd0, instr_valid_o}, {31'd0, resp});
         @(posedge clk_i); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // reset state, with a request pending to confirm no grant leaks out
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h100;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check_eq("rst_gnt", {31'd0, instr_gnt_o}, 32'd0);
      check_eq("rst_valid", {31'd0, instr_valid_o}, 32'd0);
      check_eq("rst_data", instr_data_o, 32'd0);
      check_eq("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
      check_eq("rst_mem_addr", mem_addr_o, 32'd0);
      check_eq("rst_miss", {31'd0, miss_o}, 32'd0);
      instr_req_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      // cold miss
      fetch(32'h100, 32'hA0, 1'b1, waits);
      serve(32'h100, 2, 32'hA0, 4, 1'b0, 0, 1'b1);
      check_eq("cold_miss_cnt", miss_seen, 1);

      // back-to-back hits, one grant per cycle
      req_before = mem_req_seen;
      fetch(32'h104, 32'hA1, 1'b1, waits);
      check_eq("hit1_wait", waits, 0);
      fetch(32'h108, 32'hA2, 1'b1, waits);
      check_eq("hit2_wait", waits, 0);
      fetch(32'h10C, 32'hA3, 1'b1, waits);
      check_eq("hit3_wait", waits, 0);
      @(posedge clk_i); #1;
      check_eq("hits_miss_cnt", miss_seen, 1);
      check_eq("hits_no_mem_req", mem_req_seen - req_before, 0);

      // conflict at index 0x10
      fetch(32'h500, 32'hB0, 1'b1, waits);
      serve(32'h500, 0, 32'hB0, 4, 1'b0, 0, 1'b1);
      check_eq("conflict_miss_cnt", miss_seen, 2);
      fetch(32'h100, 32'hA0, 1'b1, waits);
      serve(32'h100, 1, 32'hA0, 4, 1'b0, 0, 1'b1);
      check_eq("refetch_miss_cnt", miss_seen, 3);

      // flush on second beat kills the refill
      fetch(32'h200, 32'h0, 1'b0, waits);
      serve(32'h200, 1, 32'hD0, 4, 1'b0, 2, 1'b0);
      check_eq("flush_state", 32'(dut.state_q), 32'(IDLE));
      check_eq("flush_miss_cnt", miss_seen, 4);
      fetch(32'h200, 32'hD0, 1'b1, waits);
      serve(32'h200, 0, 32'hD0, 4, 1'b0, 0, 1'b1);
      check_eq("flush_refetch_miss", miss_seen, 5);

      // reset in the middle of a refill
      fetch(32'h300, 32'h0, 1'b0, waits);
      serve(32'h300, 0, 32'hE0, 2, 1'b0, 0, 1'b0);
      check_eq("pre_rst_state", 32'(dut.state_q), 32'(REFILL_DATA));
      #2 rst_i = 1'b1;
      #1;
      check_eq("async_rst_mem_req", {31'd0, mem_req_o}, 32'd0);
      check_eq("async_rst_mem_addr", mem_addr_o, 32'd0);
      check_eq("async_rst_valid", {31'd0, instr_valid_o}, 32'd0);
      check_eq("async_rst_data", instr_data_o, 32'd0);
      check_eq("async_rst_state", 32'(dut.state_q), 32'(IDLE));
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      for (int b = 2; b < 4; b++) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = 32'hE0 + 32'(b);
         @(posedge clk_i); #1;
      end
      mem_rvalid_i = 1'b0;
      check_eq("stale_beats_state", 32'(dut.state_q), 32'(IDLE));
      fetch(32'h300, 32'hE0, 1'b1, waits);
      serve(32'h300, 0, 32'hE0, 4, 1'b0, 0, 1'b1);
      check_eq("post_rst_miss_cnt", miss_seen, 7);

      // flush in IDLE blocks the grant and invalidates
      flush_i      = 1'b1;
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h10E;
      @(negedge clk_i);
      check_eq("flush_no_gnt", {31'd0, instr_gnt_o}, 32'd0);
      @(posedge clk_i); #1;
      flush_i = 1'b0;

      // gapped refill, unaligned fetch address returns word 3
      fetch(32'h10E, 32'hC3, 1'b1, waits);
      serve(32'h100, 0, 32'hC0, 4, 1'b1, 0, 1'b1);
      check_eq("gap_miss_cnt", miss_seen, 8);
      fetch(32'h100, 32'hC0, 1'b1, waits);
      fetch(32'h104, 32'hC1, 1'b1, waits);
      fetch(32'h108, 32'hC2, 1'b1, waits);
      @(posedge clk_i);
      @(negedge clk_i);
      check_eq("idle_valid", {31'd0, instr_valid_o}, 32'd0);
      check_eq("data_hold", instr_data_o, 32'hC2);
      check_eq("gap_hits_miss_cnt", miss_seen, 8);
      check_eq("scoreboard_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
